uop_issue_ctrl: RTL and testbench



---
 rtl/uop_pkg.sv | 12 +
 rtl/uop_result_fifo.sv | 86 ++++++++
 rtl/uop_issue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uop_issue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uop_pkg.sv
// Shared sizing helpers for the uop issue/collection controller and its result FIFO.
package uop_pkg;

    function automatic int unsigned issue_cnt_w(input int unsigned lat);
        return $clog2(lat + 32'd2);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

endpackage

// File: rtl/uop_result_fifo.sv
// Synchronous result FIFO with a registered head output; pointers wrap modulo DEPTH,
// so non-power-of-two depths are supported.
module uop_result_fifo
    import uop_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic [W-1:0]     head_o
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     head_q;
    logic             push_s, pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = head_q;
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;

    // Next-state memory, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and state registers; the head is looked up from the post-update memory so a
    // push into an empty FIFO is visible the very next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= mem_d[rd_ptr_d];
        end
    end

endmodule

// File: rtl/uop_issue_ctrl.sv
// Credit-based issue and in-order collection around a stall-free uop_block.
// Optional tag transport is enabled by defining UOP_ISSUE_TAG_EN.
module uop_issue_ctrl
    import uop_pkg::*;
#(
    parameter int W     = 32,
    parameter int LAT   = 1,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    localparam int SHW   = $clog2(W),
    localparam int INF_W = issue_cnt_w(LAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_src,
    input  logic [SHW-1:0]   in_shamt,
    output logic [W-1:0]     blk_src,
    output logic [SHW-1:0]   blk_shamt,
    input  logic [W-1:0]     blk_dst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_dst,
    output logic [INF_W-1:0] inflight
`ifdef UOP_ISSUE_TAG_EN
    ,
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag
`endif
);

`ifdef UOP_ISSUE_TAG_EN
    localparam int TAG_EN = 1;
`else
    localparam int TAG_EN = 0;
`endif
    localparam int FW    = W + TAG_EN * TAG_W;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = $clog2(DEPTH + LAT + 2) + 1;

    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_cnt_s;
    logic [SUM_W-1:0] used_s;
    logic [FW-1:0]    push_data_s, head_s;
    logic             fifo_full_s, fifo_empty_s;
    logic             shamt_ok_s, issue_s, cap_s, push_s, pop_s;
`ifdef UOP_ISSUE_TAG_EN
    logic [TAG_W-1:0] cap_tag_s;
`endif

    // Credit counts registered state only, so a same-cycle pop never frees a slot early.
    assign used_s     = SUM_W'(fifo_cnt_s) + SUM_W'(inflight_q);
    assign shamt_ok_s = (inflight_q == '0) || (in_shamt == shamt_q);
    assign in_ready   = (used_s < SUM_W'(DEPTH)) && shamt_ok_s;
    assign issue_s    = in_valid && in_ready;
    assign blk_src    = in_src;
    assign blk_shamt  = (inflight_q == '0) ? in_shamt : shamt_q;
    assign inflight   = inflight_q;

    generate
        if (LAT > 0) begin : g_vsr
            logic [LAT-1:0] vsr_q, vsr_d;

            // Issue marker delay line matching the block pipeline.
            always_comb begin
                vsr_d = LAT'({vsr_q, issue_s});
            end

            // Marker register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vsr_q <= '0;
                end else begin
                    vsr_q <= vsr_d;
                end
            end

            assign cap_s = vsr_q[LAT-1];
`ifdef UOP_ISSUE_TAG_EN
            logic [TAG_W-1:0] tsr_q [LAT];

            // Tag delay line running alongside the issue markers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < LAT; k++) begin
                        tsr_q[k] <= '0;
                    end
                end else begin
                    tsr_q[0] <= in_tag;
                    for (int k = 1; k < LAT; k++) begin
                        tsr_q[k] <= tsr_q[k-1];
                    end
                end
            end

            assign cap_tag_s = tsr_q[LAT-1];
`endif
        end else begin : g_no_vsr
            assign cap_s = issue_s;
`ifdef UOP_ISSUE_TAG_EN
            assign cap_tag_s = in_tag;
`endif
        end
    endgenerate

    // In-flight count and the shift amount held while words are in the pipeline.
    always_comb begin
        inflight_d = inflight_q;
        shamt_d    = shamt_q;
        case ({issue_s, cap_s})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase
        if (issue_s) begin
            shamt_d = in_shamt;
        end else begin
            shamt_d = shamt_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            shamt_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            shamt_q    <= shamt_d;
        end
    end

`ifdef UOP_ISSUE_TAG_EN
    assign push_data_s = {cap_tag_s, blk_dst};
    assign out_tag     = head_s[FW-1:W];
    assign out_dst     = head_s[W-1:0];
`else
    assign push_data_s = blk_dst;
    assign out_dst     = head_s;
`endif
    assign push_s    = cap_s && !fifo_full_s;
    assign pop_s     = out_valid && out_ready;
    assign out_valid = !fifo_empty_s;

    uop_result_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_cnt_s),
        .head_o      (head_s)
    );

endmodule

// File: tb/tb_uop_issue_ctrl.sv
// Directed bench for uop_issue_ctrl: LAT=2/DEPTH=4 table, reset flush, LAT=0/DEPTH=1 rate,
// and (with UOP_ISSUE_TAG_EN) LAT=3 tag alignment. Block model: dst = src << shamt.
module tb_uop_issue_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_src, a_blk_src, a_blk_dst, a_out_dst, a_d1, a_d2;
    logic [4:0]  a_in_shamt, a_blk_shamt;
    logic [1:0]  a_inflight;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_src, b_blk_src, b_blk_dst, b_out_dst;
    logic [4:0]  b_in_shamt, b_blk_shamt;
    logic [0:0]  b_inflight;

`ifdef UOP_ISSUE_TAG_EN
    logic [3:0]  a_out_tag, b_out_tag, c_in_tag, c_out_tag;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_src, c_blk_src, c_blk_dst, c_out_dst, c_d1, c_d2, c_d3;
    logic [4:0]  c_in_shamt, c_blk_shamt;
    logic [2:0]  c_inflight;
`endif

    uop_issue_ctrl #(.W(32), .LAT(2), .DEPTH(4), .TAG_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_src(a_in_src), .in_shamt(a_in_shamt), .blk_src(a_blk_src),
        .blk_shamt(a_blk_shamt), .blk_dst(a_blk_dst), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_dst(a_out_dst), .inflight(a_inflight)
`ifdef UOP_ISSUE_TAG_EN
        , .in_tag(4'd0), .out_tag(a_out_tag)
`endif
    );

    uop_issue_ctrl #(.W(32), .LAT(0), .DEPTH(1), .TAG_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_src(b_in_src), .in_shamt(b_in_shamt), .blk_src(b_blk_src),
        .blk_shamt(b_blk_shamt), .blk_dst(b_blk_dst), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_dst(b_out_dst), .inflight(b_inflight)
`ifdef UOP_ISSUE_TAG_EN
        , .in_tag(4'd0), .out_tag(b_out_tag)
`endif
    );

`ifdef UOP_ISSUE_TAG_EN
    uop_issue_ctrl #(.W(32), .LAT(3), .DEPTH(4), .TAG_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_src(c_in_src), .in_shamt(c_in_shamt), .blk_src(c_blk_src),
        .blk_shamt(c_blk_shamt), .blk_dst(c_blk_dst), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_dst(c_out_dst), .inflight(c_inflight),
        .in_tag(c_in_tag), .out_tag(c_out_tag)
    );

    always @(posedge clk) begin
        c_d1 <= c_blk_src;
        c_d2 <= c_d1;
        c_d3 <= c_d2;
    end
    assign c_blk_dst = c_d3 << c_blk_shamt;
`endif

    // Block models: src delayed by LAT, shifted by the shamt currently presented.
    always @(posedge clk) begin
        a_d1 <= a_blk_src;
        a_d2 <= a_d1;
    end
    assign a_blk_dst = a_d2 << a_blk_shamt;
    assign b_blk_dst = b_blk_src << b_blk_shamt;

    typedef struct {
        logic        v;
        logic [31:0] src;
        logic [4:0]  sh;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_dst;
        logic [1:0]  e_inf;
        logic [4:0]  e_bsh;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [31:0] src, input logic [4:0] sh,
                                input logic ordy, input logic e_rdy, input logic e_ov,
                                input logic [31:0] e_dst, input logic [1:0] e_inf,
                                input logic [4:0] e_bsh);
        vec_t r;
        r.v = v; r.src = src; r.sh = sh; r.ordy = ordy; r.e_rdy = e_rdy;
        r.e_ov = e_ov; r.e_dst = e_dst; r.e_inf = e_inf; r.e_bsh = e_bsh;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1);
    end

    initial begin
        // Three back-to-back issues, output always ready.
        vecs.push_back(mk(1'b1, 32'h10, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0,  2'd0, 5'd2));
        vecs.push_back(mk(1'b1, 32'h20, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0,  2'd1, 5'd2));
        vecs.push_back(mk(1'b1, 32'h30, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0,  2'd2, 5'd2));
        vecs.push_back(mk(1'b0, 32'h0,  5'd2, 1'b1, 1'b1, 1'b1, 32'h40, 2'd2, 5'd2));
        vecs.push_back(mk(1'b0, 32'h0,  5'd2, 1'b1, 1'b1, 1'b1, 32'h80, 2'd1, 5'd2));
        vecs.push_back(mk(1'b0, 32'h0,  5'd2, 1'b1, 1'b1, 1'b1, 32'hC0, 2'd0, 5'd2));
        // Output stalled: only DEPTH words are accepted, then drain.
        vecs.push_back(mk(1'b1, 32'h1,  5'd1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0, 5'd1));
        vecs.push_back(mk(1'b1, 32'h2,  5'd1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd1, 5'd1));
        vecs.push_back(mk(1'b1, 32'h3,  5'd1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd2, 5'd1));
        vecs.push_back(mk(1'b1, 32'h4,  5'd1, 1'b0, 1'b1, 1'b1, 32'h2,  2'd2, 5'd1));
        vecs.push_back(mk(1'b1, 32'h5,  5'd1, 1'b0, 1'b0, 1'b1, 32'h2,  2'd2, 5'd1));
        vecs.push_back(mk(1'b1, 32'h5,  5'd1, 1'b0, 1'b0, 1'b1, 32'h2,  2'd1, 5'd1));
        vecs.push_back(mk(1'b1, 32'h5,  5'd1, 1'b0, 1'b0, 1'b1, 32'h2,  2'd0, 5'd1));
        vecs.push_back(mk(1'b1, 32'h5,  5'd1, 1'b0, 1'b0, 1'b1, 32'h2,  2'd0, 5'd1));
        vecs.push_back(mk(1'b1, 32'h5,  5'd1, 1'b1, 1'b0, 1'b1, 32'h2,  2'd0, 5'd1));
        vecs.push_back(mk(1'b1, 32'h5,  5'd1, 1'b1, 1'b1, 1'b1, 32'h4,  2'd0, 5'd1));
        vecs.push_back(mk(1'b1, 32'h6,  5'd1, 1'b1, 1'b1, 1'b1, 32'h6,  2'd1, 5'd1));
        vecs.push_back(mk(1'b0, 32'h0,  5'd1, 1'b1, 1'b1, 1'b1, 32'h8,  2'd2, 5'd1));
        vecs.push_back(mk(1'b0, 32'h0,  5'd1, 1'b1, 1'b1, 1'b1, 32'hA,  2'd1, 5'd1));
        vecs.push_back(mk(1'b0, 32'h0,  5'd1, 1'b1, 1'b1, 1'b1, 32'hC,  2'd0, 5'd1));
        // Shift-amount hazard: shamt=5 waits for the shamt=3 word to drain.
        vecs.push_back(mk(1'b1, 32'h3,  5'd3, 1'b1, 1'b1, 1'b0, 32'h0,  2'd0, 5'd3));
        vecs.push_back(mk(1'b1, 32'h5,  5'd5, 1'b1, 1'b0, 1'b0, 32'h0,  2'd1, 5'd3));
        vecs.push_back(mk(1'b1, 32'h5,  5'd5, 1'b1, 1'b0, 1'b0, 32'h0,  2'd1, 5'd3));
        vecs.push_back(mk(1'b1, 32'h5,  5'd5, 1'b1, 1'b1, 1'b1, 32'h18, 2'd0, 5'd5));
        vecs.push_back(mk(1'b0, 32'h0,  5'd5, 1'b1, 1'b1, 1'b0, 32'h0,  2'd1, 5'd5));
        vecs.push_back(mk(1'b0, 32'h0,  5'd5, 1'b1, 1'b1, 1'b0, 32'h0,  2'd1, 5'd5));
        vecs.push_back(mk(1'b0, 32'h0,  5'd5, 1'b1, 1'b1, 1'b1, 32'hA0, 2'd0, 5'd5));
        vecs.push_back(mk(1'b0, 32'h0,  5'd5, 1'b1, 1'b1, 1'b0, 32'h0,  2'd0, 5'd5));

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_src = 32'h0; a_in_shamt = 5'd7; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_src = 32'h0; b_in_shamt = 5'd0; b_out_ready = 1'b0;
`ifdef UOP_ISSUE_TAG_EN
        c_in_valid = 1'b0; c_in_src = 32'h0; c_in_shamt = 5'd0; c_out_ready = 1'b0;
        c_in_tag = 4'd0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready",  32'(a_in_ready),  32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_dst",   a_out_dst,        32'h0);
        chk("rst_inflight",  32'(a_inflight),  32'd0);
        chk("rst_blk_shamt", 32'(a_blk_shamt), 32'd7);
        chk("rst_b_ready",   32'(b_in_ready),  32'd1);
`ifdef UOP_ISSUE_TAG_EN
        chk("rst_out_tag",   32'(c_out_tag),   32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            a_in_valid  = vecs[i].v;
            a_in_src    = vecs[i].src;
            a_in_shamt  = vecs[i].sh;
            a_out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i),  32'(a_in_ready),  32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_out_valid", i), 32'(a_out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_inflight", i),  32'(a_inflight),  32'(vecs[i].e_inf));
            chk($sformatf("v%0d_blk_shamt", i), 32'(a_blk_shamt), 32'(vecs[i].e_bsh));
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_out_dst", i), a_out_dst, vecs[i].e_dst);
            end
        end

        // Reset with two words in flight and one buffered, then a lone fresh word.
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            a_in_src   = 32'h55 + 32'h11 * 32'(k);
            a_in_shamt = 5'd0;
            #1;
            chk($sformatf("pre_rst_issue%0d", k), 32'(a_in_ready), 32'd1);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        chk("pre_rst_inflight",  32'(a_inflight),  32'd2);
        chk("pre_rst_out_valid", 32'(a_out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("mid_rst_inflight",  32'(a_inflight),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst_idle%0d_valid", k), 32'(a_out_valid), 32'd0);
            chk($sformatf("post_rst_idle%0d_infl", k),  32'(a_inflight),  32'd0);
        end
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_src   = 32'hAB;
        #1;
        chk("post_rst_ab_ready", 32'(a_in_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            #1;
            chk($sformatf("post_rst_ab_t%0d_valid", k), 32'(a_out_valid), 32'(k == 3));
            if (k == 3) begin
                chk("post_rst_ab_dst", a_out_dst, 32'hAB);
            end
        end

        // LAT=0, DEPTH=1: one word every two cycles, output one cycle after issue.
        b_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_src   = 32'h100 + 32'(k / 2);
            #1;
            chk($sformatf("lat0_c%0d_ready", k), 32'(b_in_ready),  32'(k % 2 == 0));
            chk($sformatf("lat0_c%0d_valid", k), 32'(b_out_valid), 32'(k % 2 == 1));
            chk($sformatf("lat0_c%0d_infl", k),  32'(b_inflight),  32'd0);
            if (k % 2 == 1) begin
                chk($sformatf("lat0_c%0d_dst", k), b_out_dst, 32'h100 + 32'(k / 2));
            end
        end
        @(negedge clk);
        b_in_valid = 1'b0;

`ifdef UOP_ISSUE_TAG_EN
        // LAT=3 tags with the output stalled, then drained in order.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            c_in_valid = 1'b1;
            c_in_src   = 32'h11 * 32'(k + 1);
            c_in_tag   = 4'(k + 1);
            #1;
            chk($sformatf("tag_issue%0d_ready", k), 32'(c_in_ready), 32'd1);
        end
        @(negedge clk);
        c_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("tag_stall_valid", 32'(c_out_valid), 32'd1);
        chk("tag_stall_dst",   c_out_dst,        32'h11);
        chk("tag_stall_tag",   32'(c_out_tag),   32'd1);
        @(negedge clk);
        c_out_ready = 1'b1;
        #1;
        chk("tag_hold_dst", c_out_dst,      32'h11);
        chk("tag_hold_tag", 32'(c_out_tag), 32'd1);
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("tag_drain%0d_valid", k), 32'(c_out_valid), 32'd1);
            chk($sformatf("tag_drain%0d_dst", k),   c_out_dst,        32'h11 * 32'(k));
            chk($sformatf("tag_drain%0d_tag", k),   32'(c_out_tag),   32'(k));
        end
        @(negedge clk);
        #1;
        chk("tag_drained_valid", 32'(c_out_valid), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
